// File: rtl/posit_pkg.sv
// posit_pkg: shared posit geometry helpers and special bit patterns.
package posit_pkg;
  function automatic int posit_regi(input int w);
    return $clog2(w) + 1;
  endfunction
  function automatic int posit_sfw(input int w, input int es);
    return posit_regi(w) + es + 1;
  endfunction
  function automatic int posit_maxsf(input int w, input int es);
    return (w - 2) * (2 ** es);
  endfunction
  // longest regime run, reached by k = +maxk (ones) before the terminator
  function automatic int posit_mts(input int w);
    return w - 1;
  endfunction
  function automatic logic [63:0] nar_code(input int w);
    return 64'd1 << (w - 1);
  endfunction
  function automatic logic [63:0] maxpos_code(input int w);
    return (64'd1 << (w - 1)) - 64'd1;
  endfunction
endpackage

// File: rtl/posit_rne_round.sv
// posit_rne_round: round-to-nearest-even on a posit body, saturating at maxpos.
module posit_rne_round #(
  parameter int BW = 7
) (
  input  logic [BW-1:0] body,
  input  logic          lsb,
  input  logic          guard,
  input  logic          sticky,
  output logic [BW-1:0] rounded
);
  assign rounded = (guard && (lsb || sticky) && !(&body)) ? body + BW'(1) : body;
endmodule

// File: rtl/posit_encoder.sv
// posit_encoder: three-stage stall-all pipeline turning a decoded operand into a WIDTH-bit posit.
module posit_encoder
  import posit_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int EXP = 2,
  parameter int FW = 8,
  localparam int SFW = posit_sfw(WIDTH, EXP)
) (
  input  logic             clk_i,
  input  logic             rst,
  input  logic             vld_i,
  output logic             rdy_o,
  input  logic             sign_i,
  input  logic             zero_i,
  input  logic             nar_i,
  input  logic [SFW-1:0]   sf_i,
  input  logic [FW-1:0]    frac_i,
  input  logic             sticky_i,
  output logic             vld_o,
  input  logic             rdy_i,
  output logic [WIDTH-1:0] posit_o
);
  localparam int REGI = posit_regi(WIDTH);
  localparam int MAXSF = posit_maxsf(WIDTH, EXP);
  localparam int MTS = posit_mts(WIDTH);
  localparam int KW = REGI + 1;
  localparam int BW = WIDTH - 1;
  localparam int WL = MTS + 1 + EXP + FW;
  localparam logic [WIDTH-1:0] NAR = WIDTH'(nar_code(WIDTH));
  localparam logic signed [SFW-1:0] SF_MAX = SFW'(MAXSF);
  logic en;
  logic v1, sg1, z1, n1, st1;
  logic [KW-1:0] k1;
  logic [EXP-1:0] e1;
  logic [FW-1:0] f1;
  logic v2, sg2, z2, n2, lsb2, g2, st2;
  logic [BW-1:0] b2;
  logic signed [SFW-1:0] sf_s, sf_c;
  logic [KW-1:0] run;
  logic [WL-1:0] sh;
  logic [BW-1:0] rounded;
  logic [WIDTH-1:0] pos, res;
  assign en = !vld_o || rdy_i;
  assign rdy_o = en;
  always_comb begin
    sf_s = $signed(sf_i);
    sf_c = sf_s > SF_MAX ? SF_MAX : (sf_s < -SF_MAX ? -SF_MAX : sf_s);
  end
  // a run of ones (k>=0) is one longer than a run of zeros (k<0) for the same |k|
  assign run = k1[KW-1] ? -k1 : k1 + KW'(1);
  assign sh = WL'({{WL{~k1[KW-1]}}, k1[KW-1], e1, f1, {MTS{1'b0}}} >> run);
  posit_rne_round #(.BW(BW)) u_rnd (
    .body   (b2),
    .lsb    (lsb2),
    .guard  (g2),
    .sticky (st2),
    .rounded(rounded)
  );
  assign pos = {1'b0, rounded};
  assign res = n2 ? NAR : z2 ? '0 : sg2 ? -pos : pos;
  always_ff @(posedge clk_i or posedge rst) begin
    if (rst) begin
      {v1, sg1, z1, n1, st1, k1, e1, f1} <= '0;
      {v2, sg2, z2, n2, lsb2, g2, st2, b2} <= '0;
      vld_o <= 1'b0;
      posit_o <= '0;
    end else if (en) begin
      v1 <= vld_i;
      sg1 <= sign_i;
      z1 <= zero_i;
      n1 <= nar_i;
      st1 <= sticky_i;
      k1 <= sf_c[SFW-1:EXP];
      e1 <= sf_c[EXP-1:0];
      f1 <= frac_i;
      v2 <= v1;
      sg2 <= sg1;
      z2 <= z1;
      n2 <= n1;
      b2 <= sh[WL-1:WL-BW];
      lsb2 <= sh[WL-BW];
      g2 <= sh[WL-BW-1];
      st2 <= st1 | (|sh[WL-BW-2:0]);
      vld_o <= v2;
      posit_o <= res;
    end
  end
endmodule

// File: doc/posit_encoder.md
# posit_encoder

Pipelined posit encoder: converts a decoded operand (sign, signed scale factor, fraction, zero/NaR flags) into a WIDTH-bit posit with round-to-nearest-even. It is the inverse of the existing `decoder` block. It is the shared back end for the posit_logmac accumulator output path and for future posit datapaths. Valid/ready streaming, one result per cycle.

## Interface
- WIDTH, 8: posit width.
- EXP, 2: exponent field bits (es).
- FW, 8: input fraction bits, hidden bit excluded, MSB-aligned.
- Derived localparams:
  - REGI = $clog2(WIDTH)+1.
  - SFW = REGI+EXP+1.
  - MAXSF = (WIDTH-2)*2^EXP.

- clk_i  in  1  clock.
- rst  in  1  reset; one clock, asynchronous, active-high.
- vld_i  in  1  input operand valid.
- rdy_o  out  1  encoder can accept an operand.
- sign_i  in  1  operand sign (1 = negative).
- zero_i  in  1  operand is exactly zero.
- nar_i  in  1  operand is NaR.
- sf_i  in  SFW  signed scale factor, value = 1.frac × 2^sf.
- frac_i  in  FW  fraction bits below the hidden 1.
- sticky_i  in  1  OR of fraction bits dropped upstream.
- vld_o  out  1  result valid.
- rdy_i  in  1  downstream accepts result.
- posit_o  out  WIDTH  encoded posit.

## Operation
- Transfer rules:
  - An input transfers when vld_i && rdy_o.
  - An output transfers when vld_o && rdy_i.
- Special cases have priority nar_i > zero_i > normal:
  - NaR → 1 followed by WIDTH-1 zeros.
  - zero → all zeros.
  - sign_i is ignored for both.
- Clamp: sf_i is saturated to [-MAXSF, +MAXSF].
  - Values above MAXSF encode ±maxpos.
  - Values below -MAXSF encode ±minpos.
  - A normal operand never encodes to zero or NaR.
- Field split: k = sf >>> EXP (floor), e = sf[EXP-1:0].
- Regime:
  - k ≥ 0: k+1 ones, then a zero.
  - k < 0: -k zeros, then a one.
- Body string is regime ‖ e ‖ frac_i, left-aligned. Keep the top WIDTH-1 bits as the body.
  - lsb = last kept bit.
  - guard = first dropped bit.
  - sticky = OR of the remaining dropped bits, OR sticky_i.
- RNE: increment the body when guard && (lsb || sticky).
  - No increment when the body is all ones (maxpos never wraps into NaR).
- Output:
  - Positive: {0, body}.
  - Negative: two's complement of {0, body}.

## Timing
- Three register stages:
  - S1: clamp, k/e split, special flags.
  - S2: regime build and shift, lsb/guard/sticky.
  - S3: round, negate, special-case mux; drives posit_o/vld_o.
- Latency: 3 cycles from input transfer to vld_o, with rdy_i held at 1. Throughput: 1 per cycle.
- Stall-all pipeline:
  - en = !vld_o || rdy_i, and rdy_o = en (combinational).
  - All stages hold while en = 0. Bubbles are not compacted.
- posit_o and vld_o are stable while vld_o && !rdy_i.
- Reset values:
  - All stage valids = 0, posit_o = 0, vld_o = 0.
  - rdy_o = 1 while rst is deasserted.
- Reset mid-operation discards all in-flight operands, with no partial output.
- Operands with vld_i = 0 propagate as bubbles; their data is don't-care but registered deterministically.

## Structure
- Package posit_pkg holds:
  - localparam helpers for REGI, MTS, SFW, MAXSF.
  - functions nar_code(WIDTH) and maxpos_code(WIDTH).
  - These are shared with decoder and posit_logmac.
- One combinational sub-module, posit_rne_round, is instantiated in S3.
  - Inputs: body, lsb, guard, sticky.
  - Output: rounded body.
  - Also reused by the MAC output path.

## Test plan
All scenarios use WIDTH=8, EXP=2, FW=8.
- sf=0, frac=0x00, sign 0/1 → 0x40 / 0xC0. sf=1, frac=0x80 → 0x4C.
- Ties and rounding at sf=0:
  - frac=0x10, sticky_i=0 → 0x40 (tie, even kept).
  - frac=0x30 → 0x42 (tie, round up).
  - frac=0x10, sticky_i=1 → 0x41.
- Saturation:
  - sf=+30 → 0x7F; sign=1 → 0x81.
  - sf=-30 → 0x01; sf=-24 → 0x01.
  - sf=24, frac=0xFF → 0x7F (no wrap).
- Special cases:
  - nar_i=1, zero_i=1, sign 1 → 0x80.
  - zero_i=1, sign 1 → 0x00.
- Backpressure:
  - Hold rdy_i=0 and offer 4 back-to-back operands → exactly 3 accepted, then rdy_o=0.
  - Release rdy_i → the 4 results emerge in order, no loss or duplication, posit_o stable while stalled.
- Reset:
  - Assert rst with 3 operands in flight → vld_o=0 and posit_o=0 immediately.
  - After release, the first new operand appears 3 cycles after acceptance.
